cdc_bus_fifo_responder: RTL and testbench



---
 rtl/cdc_bus_fifo_responder.sv | 154 +++++++++++++++
 tb/tb_cdc_bus_fifo_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_bus_fifo_responder.sv
// Peripheral-side responder for the clock-domain-crossed CPU bus: a 4-register
// window with registered reads and a TX FIFO drained over a valid/ready stream.
module cdc_bus_fifo_responder #(
   parameter logic [31:0] base_address = 32'h0000_9000,
   parameter int unsigned data_width   = 32,
   parameter int unsigned fifo_depth   = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  cpu_reset_i,
   input  logic [31:0]           address_i,
   input  logic [data_width-1:0] data_i,
   input  logic                  we_i,
   output logic [data_width-1:0] data_o,
   output logic                  module_busy_o,
   output logic [data_width-1:0] m_data_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic                  irq_o
);

   localparam int unsigned ptr_w = $clog2(fifo_depth);
   localparam int unsigned cnt_w = ptr_w + 1;
   localparam logic [cnt_w-1:0] full_lvl = cnt_w'(fifo_depth);

   logic                  en_q, en_d, ie_q, ie_d, ovf_q, ovf_d;
   logic                  pending_q, pending_d, we_q;
   logic [data_width-1:0] pend_data_q, pend_data_d;
   logic [data_width-1:0] mem_q [fifo_depth];
   logic [ptr_w-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [cnt_w-1:0]      count_q, count_d;
   logic [data_width-1:0] data_q, m_data_q;
   logic                  busy_q, m_valid_q, irq_q;

   logic                  rst, hit, wr, wr_ctrl, wr_tx, wr_clr, flush;
   logic                  full, empty, pop, push, push_pend;
   logic [1:0]            offset;
   logic [data_width-1:0] push_data, rdata, head_d;
   logic                  unused_addr;

   assign unused_addr   = ^address_i[1:0];
   assign data_o        = data_q;
   assign module_busy_o = busy_q;
   assign m_data_o      = m_data_q;
   assign m_valid_o     = m_valid_q;
   assign irq_o         = irq_q;

   // Decode, FIFO/pending bookkeeping and read mux
   always_comb begin
      rst         = reset_i | cpu_reset_i;
      hit         = (address_i[31:4] == base_address[31:4]);
      offset      = address_i[3:2];
      wr          = we_i & ~we_q & hit;
      wr_ctrl     = wr & (offset == 2'd0);
      wr_tx       = wr & (offset == 2'd2);
      wr_clr      = wr & (offset == 2'd3);
      flush       = wr_ctrl & data_i[1];
      full        = (count_q == full_lvl);
      empty       = (count_q == '0);
      pop         = m_valid_q & m_ready_i;
      push_pend   = pending_q & (~full | pop) & ~flush;
      push        = push_pend | (wr_tx & ~full & ~pending_q & ~flush);
      push_data   = pending_q ? pend_data_q : data_i;

      en_d        = en_q;
      ie_d        = ie_q;
      ovf_d       = ovf_q;
      pending_d   = pending_q;
      pend_data_d = pend_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q + cnt_w'(push) - cnt_w'(pop);

      if (wr_ctrl) begin
         en_d = data_i[0];
         ie_d = data_i[2];
      end
      if (wr_clr && data_i[0]) ovf_d = 1'b0;
      // A second TX write while one is already parked is a protocol violation
      if (wr_tx && pending_q) ovf_d = 1'b1;
      if (push_pend) pending_d = 1'b0;
      if (wr_tx && full && !pending_q) begin
         pending_d   = 1'b1;
         pend_data_d = data_i;
      end
      if (push) wr_ptr_d = wr_ptr_q + ptr_w'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_w'(1);
      if (flush) begin
         if (pending_q) ovf_d = 1'b1;
         pending_d = 1'b0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
      end

      // Head after this edge; bypass when the word being pushed becomes the head
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];

      rdata = '0;
      if (hit) begin
         case (offset)
            2'd0: begin
               rdata[0] = en_q;
               rdata[2] = ie_q;
            end
            2'd1: begin
               rdata[4:0] = 5'(count_q);
               rdata[8]   = empty;
               rdata[9]   = full;
               rdata[10]  = ovf_q;
               rdata[11]  = pending_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         en_q        <= 1'b0;
         ie_q        <= 1'b0;
         ovf_q       <= 1'b0;
         pending_q   <= 1'b0;
         pend_data_q <= '0;
         we_q        <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_q      <= '0;
         busy_q      <= 1'b0;
         m_data_q    <= '0;
         m_valid_q   <= 1'b0;
         irq_q       <= 1'b0;
         for (int i = 0; i < int'(fifo_depth); i++) mem_q[i] <= '0;
      end else begin
         en_q        <= en_d;
         ie_q        <= ie_d;
         ovf_q       <= ovf_d;
         pending_q   <= pending_d;
         pend_data_q <= pend_data_d;
         we_q        <= we_i;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         data_q      <= rdata;
         busy_q      <= pending_d;
         m_data_q    <= head_d;
         m_valid_q   <= en_d & (count_d != '0);
         irq_q       <= ovf_d | (ie_d & (count_d == '0));
         if (push) mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: tb/tb_cdc_bus_fifo_responder.sv
// Directed bench for cdc_bus_fifo_responder: a queue-based model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_cdc_bus_fifo_responder;

   localparam int unsigned depth = 4;
   localparam logic [31:0] base   = 32'h0000_9000;
   localparam logic [31:0] a_ctrl = base;
   localparam logic [31:0] a_stat = base + 32'd4;
   localparam logic [31:0] a_tx   = base + 32'd8;
   localparam logic [31:0] a_clr  = base + 32'd12;

   logic        clk = 1'b0;
   logic        reset_i, cpu_reset_i, we_i, m_ready_i;
   logic [31:0] address_i, data_i;
   logic [31:0] data_o, m_data_o;
   logic        module_busy_o, m_valid_o, irq_o;

   cdc_bus_fifo_responder #(
      .base_address(base), .data_width(32), .fifo_depth(depth)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .cpu_reset_i(cpu_reset_i),
      .address_i(address_i), .data_i(data_i), .we_i(we_i),
      .data_o(data_o), .module_busy_o(module_busy_o),
      .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
      .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO contents as a queue, registers as plain flags
   logic [31:0] mq[$];
   bit          m_pend, m_ovf, m_en, m_ie, m_weq, live;
   logic [31:0] m_pend_w, rd_v, e_data, e_head;
   bit          e_busy, e_valid, e_irq;
   bit          strobe, hit, pop, pre_pend, pre_full;
   logic [1:0]  off;

   always @(negedge clk) begin : compare_and_model
      if (live) begin
         chk("data_o", data_o, e_data);
         chk("module_busy_o", 32'(module_busy_o), 32'(e_busy));
         chk("m_valid_o", 32'(m_valid_o), 32'(e_valid));
         chk("irq_o", 32'(irq_o), 32'(e_irq));
         if (e_valid) chk("m_data_o", m_data_o, e_head);
      end
      if (reset_i || cpu_reset_i) begin
         mq.delete();
         m_pend = 0; m_ovf = 0; m_en = 0; m_ie = 0; m_weq = 0;
         m_pend_w = '0; e_data = '0; live = 1;
      end else if (live) begin
         hit  = (address_i[31:4] == base[31:4]);
         off  = address_i[3:2];
         rd_v = '0;
         if (hit && off == 2'd0) rd_v = (m_en ? 32'h1 : 32'h0) | (m_ie ? 32'h4 : 32'h0);
         if (hit && off == 2'd1)
            rd_v = 32'(mq.size()) | ((mq.size() == 0) ? 32'h100 : 32'h0)
                 | ((mq.size() == int'(depth)) ? 32'h200 : 32'h0)
                 | (m_ovf ? 32'h400 : 32'h0) | (m_pend ? 32'h800 : 32'h0);
         strobe   = we_i && !m_weq && hit;
         m_weq    = we_i;
         pop      = m_en && (mq.size() > 0) && m_ready_i;
         pre_pend = m_pend;
         pre_full = (mq.size() == int'(depth));
         if (strobe && off == 2'd3 && data_i[0]) m_ovf = 0;
         if (strobe && off == 2'd0 && data_i[1]) begin
            mq.delete();
            if (m_pend) m_ovf = 1;
            m_pend = 0;
         end else begin
            if (pop) void'(mq.pop_front());
            if (pre_pend && mq.size() < int'(depth)) begin
               mq.push_back(m_pend_w);
               m_pend = 0;
            end
            if (strobe && off == 2'd2) begin
               if (pre_pend) m_ovf = 1;
               else if (pre_full) begin m_pend = 1; m_pend_w = data_i; end
               else mq.push_back(data_i);
            end
         end
         if (strobe && off == 2'd0) begin m_en = data_i[0]; m_ie = data_i[2]; end
         e_data = rd_v;
      end
      e_busy  = m_pend;
      e_valid = m_en && (mq.size() > 0);
      e_head  = (mq.size() > 0) ? mq[0] : '0;
      e_irq   = m_ovf || (m_ie && mq.size() == 0);
   end

   // Stream capture with cycle stamps
   int          cyc = 0;
   logic [31:0] cap[$];
   int          cap_cyc[$];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (m_valid_o && m_ready_i) begin
         cap.push_back(m_data_o);
         cap_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input int hold);
      address_i = a; data_i = d; we_i = 1'b1;
      repeat (hold) tick();
      we_i = 1'b0;
      tick();
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      address_i = a; we_i = 1'b0;
      tick();
      v = data_o;
   endtask

   logic [31:0] v;
   int          fall;

   initial begin
      reset_i = 1'b1; cpu_reset_i = 1'b0; address_i = '0; data_i = '0;
      we_i = 1'b0; m_ready_i = 1'b0;
      repeat (2) tick();
      reset_i = 1'b0;

      rd(a_stat, v);               chk("reset_status", v, 32'h0000_0100);
      chk("reset_valid", 32'(m_valid_o), 32'd0);
      chk("reset_irq", 32'(irq_o), 32'd0);
      rd(32'h0000_A004, v);        chk("miss_read", v, 32'd0);
      rd(a_tx, v);                 chk("txdata_read", v, 32'd0);

      // Fill with held we_i, then drain
      for (int i = 0; i < 4; i++) wr(a_tx, 32'hA1 + 32'(i), 3);
      rd(a_stat, v);               chk("fill_status", v, 32'h0000_0204);
      m_ready_i = 1'b1;
      cap.delete(); cap_cyc.delete();
      wr(a_ctrl, 32'h1, 1);
      repeat (6) tick();
      chk("drain_count", 32'(cap.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < cap.size()) chk("drain_order", cap[i], 32'hA1 + 32'(i));
      for (int i = 1; i < 4; i++)
         if (i < cap_cyc.size()) chk("drain_consecutive", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd1);

      // Push and pop in the same cycle
      m_ready_i = 1'b0;
      wr(a_tx, 32'hF1, 1);
      m_ready_i = 1'b1;
      wr(a_tx, 32'hF2, 1);
      repeat (3) tick();
      chk("pushpop_count", 32'(cap.size()), 32'd6);
      if (cap.size() == 6) chk("pushpop_last", cap[5], 32'hF2);

      // Overfill to pending, then protocol violation and clear
      wr(a_ctrl, 32'h0, 1);
      m_ready_i = 1'b0;
      cap.delete(); cap_cyc.delete();
      for (int i = 0; i < 4; i++) wr(a_tx, 32'hC1 + 32'(i), 1);
      address_i = a_tx; data_i = 32'hB5; we_i = 1'b1;
      chk("busy_before", 32'(module_busy_o), 32'd0);
      tick();
      chk("busy_next_cycle", 32'(module_busy_o), 32'd1);
      we_i = 1'b0;
      tick();
      rd(a_stat, v);               chk("pending_status", v, 32'h0000_0A04);
      wr(a_tx, 32'hEE, 1);
      rd(a_stat, v);               chk("ovf_status", v, 32'h0000_0E04);
      chk("ovf_irq", 32'(irq_o), 32'd1);
      wr(a_clr, 32'h1, 1);
      rd(a_stat, v);               chk("clear_status", v, 32'h0000_0A04);
      chk("clear_irq", 32'(irq_o), 32'd0);

      // Drain: pending word enters behind the four queued words
      m_ready_i = 1'b1;
      address_i = a_ctrl; data_i = 32'h1; we_i = 1'b1;
      tick();
      we_i = 1'b0;
      chk("busy_held", 32'(module_busy_o), 32'd1);
      fall = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (!module_busy_o && fall == 0) fall = k;
      end
      chk("busy_drop_within_2", 32'(fall >= 1 && fall <= 2), 32'd1);
      repeat (6) tick();
      chk("pend_drain_count", 32'(cap.size()), 32'd5);
      for (int i = 0; i < 4; i++)
         if (i < cap.size()) chk("pend_drain_order", cap[i], 32'hC1 + 32'(i));
      if (cap.size() >= 5) chk("pend_fifth", cap[4], 32'hB5);

      // Flush with two entries queued
      m_ready_i = 1'b0;
      wr(a_tx, 32'hD1, 1);
      wr(a_tx, 32'hD2, 1);
      chk("pre_flush_valid", 32'(m_valid_o), 32'd1);
      address_i = a_ctrl; data_i = 32'h2; we_i = 1'b1;
      tick();
      chk("flush_valid", 32'(m_valid_o), 32'd0);
      we_i = 1'b0;
      tick();
      rd(a_ctrl, v);               chk("flush_ctrl", v, 32'h0);
      rd(a_stat, v);               chk("flush_status", v, 32'h0000_0100);

      // Flush discarding a pending word sets ovf
      for (int i = 0; i < 5; i++) wr(a_tx, 32'h51 + 32'(i), 1);
      chk("flush_pend_busy", 32'(module_busy_o), 32'd1);
      wr(a_ctrl, 32'h2, 1);
      chk("flush_pend_busy_off", 32'(module_busy_o), 32'd0);
      rd(a_stat, v);               chk("flush_pend_status", v, 32'h0000_0500);
      chk("flush_pend_irq", 32'(irq_o), 32'd1);
      wr(a_clr, 32'h1, 1);

      // Empty interrupt, then cpu_reset while busy
      wr(a_ctrl, 32'h4, 1);
      chk("ie_empty_irq", 32'(irq_o), 32'd1);
      for (int i = 0; i < 5; i++) wr(a_tx, 32'h61 + 32'(i), 1);
      chk("cpurst_pre_busy", 32'(module_busy_o), 32'd1);
      cpu_reset_i = 1'b1;
      tick();
      cpu_reset_i = 1'b0;
      chk("cpurst_busy", 32'(module_busy_o), 32'd0);
      chk("cpurst_irq", 32'(irq_o), 32'd0);
      rd(a_stat, v);               chk("cpurst_status", v, 32'h0000_0100);
      rd(a_ctrl, v);               chk("cpurst_ctrl", v, 32'h0);

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
